// File: rtl/ald_pkg.sv
// Shared types and constants for the ALD valve guard stage.
package ald_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    DEAD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_CONFLICT = 2'd1;
  localparam logic [1:0] FLT_WDOG     = 2'd2;

  // Vacuum sits just above the precursor valves in the exclusive group.
  function automatic int unsigned vac_index(input int unsigned n_prec);
    return n_prec;
  endfunction

endpackage

// File: rtl/sat_tick_counter.sv
// Tick counter with synchronous clear that saturates at all-ones.
module sat_tick_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ald_valve_guard.sv
// Valve safety stage: one-open exclusion, minimum on time, break-before-make
// dead time and a stuck-open watchdog for the precursor/vacuum group.
module ald_valve_guard
  import ald_pkg::*;
#(
  parameter int unsigned N_PREC    = 3,
  parameter int unsigned DEAD_MS   = 20,
  parameter int unsigned MIN_ON_MS = 5,
  parameter int unsigned MAX_ON_MS = 5000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              scan_valid,
  input  logic [N_PREC-1:0] req_prec,
  input  logic              req_vac,
  input  logic [1:0]        req_vv,
  input  logic              fault_clr,
  output logic [N_PREC-1:0] prec_out,
  output logic              vac_out,
  output logic [1:0]        vv_out,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam int unsigned G     = N_PREC + 1;
  localparam int unsigned IDX_W = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned VAC   = vac_index(N_PREC);
  localparam logic [CNT_W-1:0] DEAD_C = CNT_W'(DEAD_MS);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_ON_MS);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_ON_MS);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic [1:0]        code_q, code_d;
  logic [G-1:0]      req_q;
  logic [1:0]        vv_q, vv_out_q;
  logic [N_PREC-1:0] prec_q;
  logic              vac_q, busy_q, fault_q;

  logic [CNT_W-1:0]  on_cnt, dead_cnt;
  logic              on_clr, dead_clr;

  int unsigned       n_set;
  logic [IDX_W-1:0]  first_idx;
  logic [G-1:0]      others;
  logic              cur_req;
  logic [G-1:0]      grp_d;

  sat_tick_counter #(.CNT_W(CNT_W)) u_on_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (on_clr),
    .en_i  (tick),
    .cnt_o (on_cnt)
  );

  sat_tick_counter #(.CNT_W(CNT_W)) u_dead_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (dead_clr),
    .en_i  (tick),
    .cnt_o (dead_cnt)
  );

  always_comb begin
    n_set     = 0;
    first_idx = '0;
    for (int unsigned i = 0; i < G; i++) begin
      if (req_q[i]) begin
        n_set     = n_set + 1;
        first_idx = IDX_W'(i);
      end
    end
    others  = req_q & ~(G'(1) << cur_q);
    cur_req = req_q[cur_q];
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    code_d   = code_q;
    on_clr   = 1'b0;
    dead_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (n_set == 1) begin
          state_d = ON;
          cur_d   = first_idx;
          on_clr  = 1'b1;
        end else if (n_set > 1) begin
          state_d = FAULT;
          code_d  = FLT_CONFLICT;
        end
      end
      ON: begin
        // Watchdog outranks both conflict and a normal close.
        if (on_cnt >= MAX_C) begin
          state_d = FAULT;
          code_d  = FLT_WDOG;
        end else if (cur_req && (others != '0)) begin
          state_d = FAULT;
          code_d  = FLT_CONFLICT;
        end else if (!cur_req && (on_cnt >= MIN_C)) begin
          state_d  = DEAD;
          dead_clr = 1'b1;
        end
      end
      DEAD: begin
        if (dead_cnt == DEAD_C) state_d = IDLE;
      end
      FAULT: begin
        if (fault_clr && (req_q == '0)) begin
          state_d  = DEAD;
          dead_clr = 1'b1;
          code_d   = FLT_NONE;
        end
      end
      default: state_d = IDLE;
    endcase

    grp_d = '0;
    if (state_d == ON) grp_d[cur_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      code_q   <= FLT_NONE;
      req_q    <= '0;
      vv_q     <= '0;
      vv_out_q <= '0;
      prec_q   <= '0;
      vac_q    <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      if (scan_valid) begin
        req_q <= {req_vac, req_prec};
        vv_q  <= req_vv;
      end
      state_q  <= state_d;
      cur_q    <= cur_d;
      code_q   <= code_d;
      vv_out_q <= vv_q;
      prec_q   <= grp_d[N_PREC-1:0];
      vac_q    <= grp_d[VAC];
      busy_q   <= (state_d != IDLE);
      fault_q  <= (state_d == FAULT);
    end
  end

  assign prec_out   = prec_q;
  assign vac_out    = vac_q;
  assign vv_out     = vv_out_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_ald_valve_guard.sv
// Directed bench for ald_valve_guard with short timing parameters.
module tb_ald_valve_guard;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       scan_valid;
  logic [2:0] req_prec;
  logic       req_vac;
  logic [1:0] req_vv;
  logic       fault_clr;
  logic [2:0] prec_out;
  logic       vac_out;
  logic [1:0] vv_out;
  logic       busy;
  logic       fault;
  logic [1:0] fault_code;

  int total = 0;
  int bad   = 0;

  ald_valve_guard #(
    .N_PREC    (3),
    .DEAD_MS   (3),
    .MIN_ON_MS (2),
    .MAX_ON_MS (10),
    .CNT_W     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .scan_valid (scan_valid),
    .req_prec   (req_prec),
    .req_vac    (req_vac),
    .req_vv     (req_vv),
    .fault_clr  (fault_clr),
    .prec_out   (prec_out),
    .vac_out    (vac_out),
    .vv_out     (vv_out),
    .busy       (busy),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic scan(input logic [2:0] p, input logic v, input logic [1:0] vv);
    req_prec   = p;
    req_vac    = v;
    req_vv     = vv;
    scan_valid = 1'b1;
    step();
    scan_valid = 1'b0;
  endtask

  task automatic go_idle(input logic [1:0] vv);
    scan(3'b000, 1'b0, vv);
    fault_clr = 1'b1;
    for (int i = 0; i < 60 && busy !== 1'b0; i++) begin
      pulse_tick();
      step();
    end
    fault_clr = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL go_idle_timeout got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 0; scan_valid = 0; req_prec = 0; req_vac = 0;
    req_vv = 0; fault_clr = 0;
    step();
    total++;
    if ({prec_out, vac_out, vv_out, busy, fault, fault_code} !== 10'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {prec_out, vac_out, vv_out, busy, fault, fault_code}, 10'b0);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_open_latency();
    scan(3'b001, 1'b0, 2'b00);
    total++;
    if (prec_out !== 3'b000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL open_at_E0 got prec=%b busy=%b exp prec=000 busy=0", prec_out, busy);
    end
    step();
    total++;
    if (prec_out !== 3'b001 || busy !== 1'b1) begin
      bad++;
      $display("FAIL open_at_E1 got prec=%b busy=%b exp prec=001 busy=1", prec_out, busy);
    end
  endtask

  task automatic test_early_drop();
    pulse_tick();
    scan(3'b000, 1'b0, 2'b00);
    step();
    total++;
    if (prec_out !== 3'b001) begin
      bad++;
      $display("FAIL early_drop_hold got=%b exp=001", prec_out);
    end
    pulse_tick();
    total++;
    if (prec_out !== 3'b001) begin
      bad++;
      $display("FAIL early_drop_min_edge got=%b exp=001", prec_out);
    end
    step();
    total++;
    if (prec_out !== 3'b000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL early_drop_close got prec=%b busy=%b exp prec=000 busy=1", prec_out, busy);
    end
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      total++;
      if (busy !== 1'b1 || prec_out !== 3'b000) begin
        bad++;
        $display("FAIL dead_hold_%0d got busy=%b prec=%b exp busy=1 prec=000", i, busy, prec_out);
      end
    end
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL dead_to_idle got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_switch();
    scan(3'b001, 1'b0, 2'b00);
    step();
    for (int i = 0; i < 4; i++) pulse_tick();
    scan(3'b010, 1'b0, 2'b00);
    total++;
    if (prec_out !== 3'b001) begin
      bad++;
      $display("FAIL switch_pre got=%b exp=001", prec_out);
    end
    step();
    total++;
    if (prec_out !== 3'b000) begin
      bad++;
      $display("FAIL switch_close got=%b exp=000", prec_out);
    end
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      total++;
      if (prec_out !== 3'b000 || $countones({vac_out, prec_out}) > 1) begin
        bad++;
        $display("FAIL switch_gap_%0d got=%b exp=000", i, prec_out);
      end
    end
    step();
    total++;
    if (prec_out !== 3'b000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL switch_idle got prec=%b busy=%b exp prec=000 busy=0", prec_out, busy);
    end
    step();
    total++;
    if (prec_out !== 3'b010) begin
      bad++;
      $display("FAIL switch_open got=%b exp=010", prec_out);
    end
    go_idle(2'b00);
  endtask

  task automatic test_conflict();
    scan(3'b011, 1'b0, 2'b00);
    step();
    total++;
    if (fault !== 1'b1 || fault_code !== 2'd1 || prec_out !== 3'b000 || vac_out !== 1'b0) begin
      bad++;
      $display("FAIL conflict_idle got fault=%b code=%0d prec=%b exp fault=1 code=1 prec=000",
               fault, fault_code, prec_out);
    end
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    total++;
    if (fault !== 1'b1 || fault_code !== 2'd1) begin
      bad++;
      $display("FAIL conflict_clr_ignored got fault=%b code=%0d exp fault=1 code=1", fault, fault_code);
    end
    scan(3'b000, 1'b0, 2'b00);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    total++;
    if (fault !== 1'b0 || fault_code !== 2'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL conflict_clear got fault=%b code=%0d busy=%b exp fault=0 code=0 busy=1",
               fault, fault_code, busy);
    end
    for (int i = 0; i < 3; i++) pulse_tick();
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL conflict_dead_end got busy=%b exp=0", busy);
    end
    // second request appearing while a valve is already open
    scan(3'b100, 1'b0, 2'b00);
    step();
    scan(3'b100, 1'b1, 2'b00);
    step();
    total++;
    if (fault_code !== 2'd1 || prec_out !== 3'b000 || vac_out !== 1'b0) begin
      bad++;
      $display("FAIL conflict_on got code=%0d prec=%b vac=%b exp code=1 prec=000 vac=0",
               fault_code, prec_out, vac_out);
    end
    go_idle(2'b00);
  endtask

  task automatic test_watchdog();
    scan(3'b000, 1'b1, 2'b01);
    total++;
    if (vv_out !== 2'b00) begin
      bad++;
      $display("FAIL vv_latency_E0 got=%b exp=00", vv_out);
    end
    step();
    total++;
    if (vac_out !== 1'b1 || vv_out !== 2'b01) begin
      bad++;
      $display("FAIL wdog_open got vac=%b vv=%b exp vac=1 vv=01", vac_out, vv_out);
    end
    for (int i = 0; i < 10; i++) pulse_tick();
    total++;
    if (vac_out !== 1'b1) begin
      bad++;
      $display("FAIL wdog_tick10_edge got=%b exp=1", vac_out);
    end
    step();
    total++;
    if (vac_out !== 1'b0 || fault !== 1'b1 || fault_code !== 2'd2 || vv_out !== 2'b01) begin
      bad++;
      $display("FAIL wdog_trip got vac=%b fault=%b code=%0d vv=%b exp vac=0 fault=1 code=2 vv=01",
               vac_out, fault, fault_code, vv_out);
    end
    pulse_tick();
    pulse_tick();
    total++;
    if (fault_code !== 2'd2 || vac_out !== 1'b0) begin
      bad++;
      $display("FAIL wdog_held got code=%0d vac=%b exp code=2 vac=0", fault_code, vac_out);
    end
    go_idle(2'b01);
    total++;
    if (vv_out !== 2'b01 || fault !== 1'b0) begin
      bad++;
      $display("FAIL wdog_recover got vv=%b fault=%b exp vv=01 fault=0", vv_out, fault);
    end
  endtask

  task automatic test_async_reset();
    scan(3'b010, 1'b0, 2'b10);
    step();
    total++;
    if (prec_out !== 3'b010) begin
      bad++;
      $display("FAIL ar_open got=%b exp=010", prec_out);
    end
    pulse_tick();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (prec_out !== 3'b000 || busy !== 1'b0 || vv_out !== 2'b00) begin
      bad++;
      $display("FAIL async_reset got prec=%b busy=%b vv=%b exp prec=000 busy=0 vv=00",
               prec_out, busy, vv_out);
    end
    #1;
    rst = 1'b0;
    step();
    step();
    total++;
    if (prec_out !== 3'b000 || busy !== 1'b0 || vv_out !== 2'b00) begin
      bad++;
      $display("FAIL post_reset_req_cleared got prec=%b busy=%b vv=%b exp all 0",
               prec_out, busy, vv_out);
    end
  endtask

  initial begin
    test_reset();
    test_open_latency();
    test_early_drop();
    test_switch();
    test_conflict();
    test_watchdog();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ald_valve_guard.md
# ald_valve_guard

Safety stage directly downstream of the ALD ladder-logic rung-scan controller. It consumes the valve commands the controller commits once per scan (precursor valves sv1..sv3, chamber vacuum valve svac1, pump valves VV1/VV2) and drives the physical valve outputs. It enforces one-open-at-a-time exclusion across the precursor/vacuum group, a minimum open time, a break-before-make dead time between valves, and a stuck-open watchdog that latches a fault and closes the group.

## Interface
- N_PREC, 3, number of precursor valves; exclusive group size is N_PREC+1, with vacuum as index N_PREC
- DEAD_MS, 20, ticks all group valves stay closed between any close and the next open
- MIN_ON_MS, 5, minimum ticks a group valve stays open once opened
- MAX_ON_MS, 5000, ticks after which a still-open group valve is a fault
- CNT_W, 16, tick counter width; all *_MS values must be < 2^CNT_W
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- tick  in  1  1 kHz single-cycle strobe from the shared DownClock
- scan_valid  in  1  single-cycle strobe; controller has committed a new command set
- req_prec  in  N_PREC  requested precursor valves (sv1 = bit 0)
- req_vac  in  1  requested chamber vacuum valve (svac1)
- req_vv  in  2  requested pump valves {VV2,VV1}
- fault_clr  in  1  operator fault acknowledge (conditioned key)
- prec_out  out  N_PREC  precursor valve drives
- vac_out  out  1  vacuum valve drive
- vv_out  out  2  pump valve drives
- busy  out  1  FSM not in IDLE
- fault  out  1  fault latched
- fault_code  out  2  0 none, 1 conflict, 2 watchdog; held while fault=1

## Operation
- req_q (N_PREC+1 bits, {req_vac,req_prec}) and vv_q are registered only on scan_valid; between scans the last committed set holds.
- vv_out = vv_q in every state, including FAULT, so pumps keep running.
- FSM states: IDLE, ON, DEAD, FAULT. Register cur holds the index of the open valve; at most one bit of {vac_out,prec_out} is ever 1, and only in ON.
- IDLE: req_q zero → stay. Exactly one bit set → ON, cur = that index, on_cnt = 0. More than one bit set → FAULT, code 1.
- ON: group output cur = 1. on_cnt increments on tick.
  - req_q has a bit other than cur set while req_q[cur] = 1 → FAULT, code 1.
  - req_q[cur] = 0 and on_cnt >= MIN_ON_MS → DEAD, dead_cnt = 0. An early drop holds the valve open until MIN_ON_MS is met.
  - on_cnt reaches MAX_ON_MS → FAULT, code 2. Watchdog has priority over a normal close in the same cycle.
- DEAD: all group outputs 0. dead_cnt increments on tick. dead_cnt == DEAD_MS → IDLE, which re-evaluates req_q. A switch to another valve therefore always passes through DEAD.
- FAULT: all group outputs 0, fault = 1. fault_clr with req_q == 0 → DEAD, with fault and fault_code cleared. fault_clr with req_q nonzero is ignored.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset (async, immediate): state IDLE, cur 0, req_q 0, vv_q 0, counters 0.
- Reset value of every output: prec_out 0, vac_out 0, vv_out 0, busy 0, fault 0, fault_code 0.
- Reset mid-ON closes the valve asynchronously, with no dead-time guarantee.
- All outputs are registered.
- scan_valid at edge E0 → req_q updated at E0. The FSM acts at E0+1, and outputs change at E0+1, so there is 1 cycle of latency from commit.
- vv_out changes at E0+1.
- Same-cycle combinations:
  - tick and scan_valid: both take effect.
  - tick and a state transition: the counter for the new state starts at 0.
  - DEAD_MS = 0: DEAD lasts exactly 1 cycle.
- Close-to-open gap: at least DEAD_MS ticks plus 1 cycle.

## Structure
- Shared package ald_pkg holds:
  - state enum (IDLE, ON, DEAD, FAULT)
  - fault code constants FLT_NONE, FLT_CONFLICT, FLT_WDOG
  - the group index constant for vacuum
- Sub-module sat_tick_counter (clear, tick enable, saturating CNT_W count), instantiated twice: once for on_cnt and once for dead_cnt.
- Onehot/popcount check on req_q stays inline.

## Test plan
Use DEAD_MS=3, MIN_ON_MS=2, MAX_ON_MS=10.
- Reset then idle: all outputs 0; scan req_prec=001 → prec_out=001 at E0+1, busy=1.
- Early drop: open sv1, drop request after 1 tick → prec_out stays 001 until tick 2, then 000; busy stays high through 3 DEAD ticks, then IDLE.
- Switch: req 001 → 010 after 4 ticks → sv1 closes, 3 ticks with prec_out=000, then prec_out=010; never two bits set.
- Conflict: scan req_prec=011 in IDLE → fault=1, fault_code=1, outputs 000. fault_clr with req nonzero → no change. req 0 then fault_clr → fault=0 after DEAD.
- Watchdog: hold req_vac=1 for 12 ticks → vac_out drops on tick 10, fault_code=2, vv_out unchanged.
- Async reset asserted while ON mid-tick → prec_out=000 immediately, before the next clk edge.
